// File: rtl/md_pkg.sv
// Shared multiply/divide op codes and scheduler state encoding, used by the
// decoder, the scheduler and the multiply/divide unit.
package md_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_MFLO  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0110;
    localparam logic [3:0] OP_MTLO  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_BUSY  = 2'b10
    } md_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return !op[3];
    endfunction

    // mult/multu/div/divu occupy the unit for a countdown
    function automatic logic op_is_long(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return op[3:1] == 3'b001;
    endfunction

    function automatic logic op_writes_hilo(input logic [3:0] op);
        return op_is_legal(op) && (op != OP_MFHI) && (op != OP_MFLO);
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter timing a long multiply/divide; reports count==1 and count>1.
module md_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o,
    output logic         gt_one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == W'(1));
    assign gt_one_o = (cnt_q >  W'(1));

endmodule

// File: rtl/md_sched.sv
// Decode-stage interlock and issue sequencer for the multiply/divide unit.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    input  logic       e_flush,
    output logic       stall,
    output logic       md_start,
    output logic       md_hlwr,
    output logic [3:0] md_op,
    output logic       md_busy,
    output logic       md_done,
    output logic       illegal_op
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e  state_q;
    logic [3:0] op_q;
    logic       illegal_q;

    logic       cnt_is_one;
    logic       cnt_gt_one;
    logic       cnt_load;
    logic [CNT_W-1:0] lat_d;

    logic       in_issue;
    logic       in_busy;
    logic       issue_long;
    logic       accept;
    logic       accept_legal;

    assign in_issue   = (state_q == ST_ISSUE);
    assign in_busy    = (state_q == ST_BUSY);
    assign issue_long = in_issue && op_is_long(op_q);

    assign stall        = req_valid && (issue_long || (in_busy && cnt_gt_one));
    assign accept       = req_valid && !stall;
    assign accept_legal = accept && op_is_legal(req_op);

    // A flushed ISSUE cycle never reaches the unit and never starts a countdown
    assign cnt_load = issue_long && !e_flush;
    assign lat_d    = op_is_div(op_q) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    md_lat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (lat_d),
        .dec_i      (in_busy),
        .is_one_o   (cnt_is_one),
        .gt_one_o   (cnt_gt_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !op_is_legal(req_op);
            if (accept_legal) begin
                op_q <= req_op;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_legal) state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (cnt_load)          state_q <= ST_BUSY;
                    else if (accept_legal) state_q <= ST_ISSUE;
                    else                   state_q <= ST_IDLE;
                end
                ST_BUSY: begin
                    if (cnt_is_one) state_q <= accept_legal ? ST_ISSUE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md_start   = in_issue && !e_flush;
    assign md_hlwr    = in_issue && !e_flush && op_writes_hilo(op_q);
    assign md_op      = op_q;
    assign md_busy    = issue_long || in_busy;
    assign md_done    = in_busy && cnt_is_one;
    assign illegal_op = illegal_q;

endmodule
